sram_bank_responder: RTL and testbench
======================================

Name: sram_bank_responder

Overview:
- Responder (SRAM side) of the SRAM controller interface: N_SRAM banks of 32-bit word storage.
- Each bank accepts single-word accesses from the SRAM controller.
- Byte-enabled writes; reads return a full word.
- A parameterised wait-state counter drives sram_wait so the controller stalls for a configurable access time.
- Used as the on-chip RAM behind the AHB SRAM controller and as its verification target.

Parameters:
N_SRAM, 1, number of banks; one sram_en bit and one ram_rData word per bank.
WORDS_PER_BANK, 1024, 32-bit words per bank; must be a power of two. Derived localparam AW = clog2(WORDS_PER_BANK).
WAIT_STATES, 1, stall cycles per access (0..15).

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous active-high reset
wen  input  1  1 = write, 0 = read
ram_wData  input  32  write data
addr  input  32  byte address; word index = addr[AW+1:2]
byte_en  input  4  byte lanes for writes; bit i covers bits 8i+7:8i
sram_en  input  N_SRAM  one-hot bank select; all zero = no access
ram_rData  output  N_SRAM x 32  per-bank registered read data
sram_wait  output  1  controller must hold all inputs stable while high

Behaviour:
- Interface decision: one clock, CLK. Reset RST is synchronous and active-high.
- Reset:
  - FSM goes to IDLE, wait counter is 0, every ram_rData word is 0, sram_wait is 0 (forced low while RST=1).
  - Storage contents are not cleared and are preserved across RST.
- FSM states are IDLE and BUSY. An access starts in cycle A when the FSM is in IDLE and sram_en != 0.
  - WAIT_STATES = 0: cycle A is the completion cycle, sram_wait stays 0, FSM stays IDLE.
  - WAIT_STATES = W > 0:
    - sram_wait is high in cycles A .. A+W-1 (combinational in cycle A, from the FSM state and sram_en).
    - Cycle A+W is the completion cycle, with sram_wait = 0.
    - FSM: IDLE -> BUSY at the end of cycle A; counter loads W-1; BUSY -> IDLE at the end of the completion cycle.
- Completion edge (rising edge ending the completion cycle), using the inputs present in that cycle:
  - Write: storage[bank][word] updates only on the lanes where byte_en=1. byte_en=0000 completes with no change. ram_rData is unchanged.
  - Read: ram_rData[bank] <= storage[bank][word]. Data is valid from the next cycle and held until that bank's next read completes. Other banks' ram_rData hold their values. byte_en is ignored.
- Back-to-back accesses: if sram_en is still nonzero in the cycle after completion, a new access starts there (new cycle A). With WAIT_STATES=0, one access completes per cycle.
- Read-after-write to the same word with no gap: the read returns the newly written data.
- Abort: if sram_en = 0 in any BUSY cycle, the FSM returns to IDLE at the end of that cycle. No write occurs, ram_rData is unchanged, and sram_wait is 0 in that cycle.
- Multi-hot sram_en (protocol violation): timing is normal, but no write occurs and no ram_rData update occurs.
- Address:
  - Upper bits addr[31:AW+2] are ignored, so addresses alias and wrap modulo WORDS_PER_BANK.
  - addr[1:0] is ignored.
- RST during BUSY: the FSM goes to IDLE at that edge. No write completes, and sram_wait is 0 during RST.

Test Plan:
- Reset:
  - Stimulus: RST high for 2 cycles, then release; sram_en=0.
  - Required: ram_rData all 0x00000000; sram_wait=0 throughout.
- Write then read (WAIT_STATES=1, N_SRAM=1):
  - Stimulus: write 0xDEADBEEF to addr 0x10 with byte_en=1111, then read addr 0x10.
  - Required: sram_wait high exactly 1 cycle per access; ram_rData[0]=0xDEADBEEF the cycle after the read completes.
- Byte enables:
  - Stimulus: write 0x11223344, then write 0xAABBCCDD with byte_en=0101, then read.
  - Required: ram_rData=0x11BB33DD.
- Wait states and back-to-back (WAIT_STATES=3):
  - Stimulus: sram_en held high for two consecutive reads.
  - Required: sram_wait pattern 1,1,1,0,1,1,1,0.
  - Stimulus (WAIT_STATES=0): 4 consecutive writes then 4 reads.
  - Required: sram_wait never high; each read's data appears the cycle after it completes.
- Abort, reset and aliasing (N_SRAM=2, WAIT_STATES=2):
  - Stimulus: drop sram_en in the second wait cycle of a write of 0x5A5A5A5A.
  - Required: a later read returns the prior value.
  - Stimulus: assert RST mid-write.
  - Required: no write occurs; earlier stored data is still readable after reset.
  - Stimulus: write to addr 0x1000 (WORDS_PER_BANK=1024), then read addr 0x0000 on the same bank.
  - Required: the read returns the same data; bank 1's ram_rData is unaffected by bank 0 accesses.

Source files
------------

// File: rtl/sram_bank_responder.sv
// SRAM-side responder: N_SRAM banks of 32-bit words with byte-enabled writes,
// registered per-bank read data and a programmable wait-state stall.
module sram_bank_responder #(
  parameter int N_SRAM         = 1,
  parameter int WORDS_PER_BANK = 1024,
  parameter int WAIT_STATES    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wen,
  input  logic [31:0]           ram_wData,
  input  logic [31:0]           addr,
  input  logic [3:0]            byte_en,
  input  logic [N_SRAM-1:0]     sram_en,
  output logic [N_SRAM*32-1:0]  ram_rData,
  output logic                  sram_wait
);

  localparam int AW = $clog2(WORDS_PER_BANK);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          active;
  logic          complete;
  logic          en_onehot;
  logic [AW-1:0] word;
  logic          unused_addr;

  assign active      = |sram_en;
  assign en_onehot   = $onehot(sram_en);
  assign word        = addr[AW+1:2];
  assign unused_addr = &{1'b0, addr[31:AW+2], addr[1:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sram_wait = 1'b0;
    complete  = 1'b0;
    unique case (state)
      IDLE: begin
        if (active) begin
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
          end else begin
            sram_wait = 1'b1;
            state_nxt = BUSY;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end
        end
      end
      BUSY: begin
        // Dropping sram_en mid-access abandons it without touching storage.
        if (!active) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else begin
          sram_wait = 1'b1;
          cnt_nxt   = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (RST) begin
      sram_wait = 1'b0;
      complete  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  for (genvar b = 0; b < N_SRAM; b++) begin : g_bank
    logic [31:0] mem [WORDS_PER_BANK];
    logic [31:0] rdata;
    logic        hit;

    // A multi-hot select completes on time but is not allowed to touch any bank.
    assign hit = complete && en_onehot && sram_en[b];

    always_ff @(posedge CLK) begin
      if (hit && wen) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en[i]) mem[word][8*i +: 8] <= ram_wData[8*i +: 8];
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        rdata <= 32'h0;
      end else if (hit && !wen) begin
        rdata <= mem[word];
      end
    end

    assign ram_rData[32*b +: 32] = rdata;
  end

endmodule

// File: tb/tb_sram_bank_responder.sv
// Directed bench for sram_bank_responder: four instances with different wait-state
// and bank-count settings share the bus signals; only one is selected at a time.
module tb_sram_bank_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        wen = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  byte_en = 4'h0;

  logic        en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic [1:0]  en_d = 2'b00;
  logic [31:0] rd_a, rd_b, rd_c;
  logic [63:0] rd_d;
  logic        wt_a, wt_b, wt_c, wt_d;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  sram_bank_responder #(.N_SRAM(1), .WORDS_PER_BANK(1024), .WAIT_STATES(1)) u_a (
    .CLK(CLK), .RST(RST), .wen(wen), .ram_wData(wdata), .addr(addr), .byte_en(byte_en),
    .sram_en(en_a), .ram_rData(rd_a), .sram_wait(wt_a));

  sram_bank_responder #(.N_SRAM(1), .WORDS_PER_BANK(1024), .WAIT_STATES(3)) u_b (
    .CLK(CLK), .RST(RST), .wen(wen), .ram_wData(wdata), .addr(addr), .byte_en(byte_en),
    .sram_en(en_b), .ram_rData(rd_b), .sram_wait(wt_b));

  sram_bank_responder #(.N_SRAM(1), .WORDS_PER_BANK(1024), .WAIT_STATES(0)) u_c (
    .CLK(CLK), .RST(RST), .wen(wen), .ram_wData(wdata), .addr(addr), .byte_en(byte_en),
    .sram_en(en_c), .ram_rData(rd_c), .sram_wait(wt_c));

  sram_bank_responder #(.N_SRAM(2), .WORDS_PER_BANK(1024), .WAIT_STATES(2)) u_d (
    .CLK(CLK), .RST(RST), .wen(wen), .ram_wData(wdata), .addr(addr), .byte_en(byte_en),
    .sram_en(en_d), .ram_rData(rd_d), .sram_wait(wt_d));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic get_wait(input int d);
    case (d)
      0:       return wt_a;
      1:       return wt_b;
      2:       return wt_c;
      default: return wt_d;
    endcase
  endfunction

  task automatic set_en(input int d, input logic [1:0] en);
    case (d)
      0:       en_a = en[0];
      1:       en_b = en[0];
      2:       en_c = en[0];
      default: en_d = en;
    endcase
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drives one access starting in the current cycle and checks sram_wait in every
  // cycle up to completion; returns just after the completion edge with sram_en still set.
  task automatic access(input string tag, input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] data, input logic [3:0] be, input logic [1:0] en,
                        input int ws);
    wen = w; addr = a; wdata = data; byte_en = be;
    set_en(d, en);
    for (int c = 0; c <= ws; c++) begin
      #1;
      chk({tag, "_wait"}, {63'h0, get_wait(d)}, {63'h0, (c < ws)});
      step();
    end
  endtask

  task automatic drop_all();
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 2'b00;
    wen = 1'b0;
    step();
  endtask

  initial begin
    // Reset: two cycles high, sram_wait low throughout
    step();
    #1 chk("rst_wait1", {60'h0, wt_a, wt_b, wt_c, wt_d}, 64'h0);
    step();
    #1 chk("rst_wait2", {60'h0, wt_a, wt_b, wt_c, wt_d}, 64'h0);
    RST = 1'b0;
    step();
    chk("rst_rd_a", {32'h0, rd_a}, 64'h0);
    chk("rst_rd_b", {32'h0, rd_b}, 64'h0);
    chk("rst_rd_c", {32'h0, rd_c}, 64'h0);
    chk("rst_rd_d", rd_d, 64'h0);
    chk("idle_wait", {60'h0, wt_a, wt_b, wt_c, wt_d}, 64'h0);

    // One wait state: write then read
    access("a_wr", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b01, 1);
    access("a_rd", 0, 1'b0, 32'h10, 32'h0, 4'h0, 2'b01, 1);
    chk("a_rd_data", {32'h0, rd_a}, {32'h0, 32'hDEADBEEF});
    drop_all();

    // Byte enables: lanes 0 and 2 only
    access("a_be1", 0, 1'b1, 32'h20, 32'h11223344, 4'hF, 2'b01, 1);
    access("a_be2", 0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 2'b01, 1);
    access("a_be_rd", 0, 1'b0, 32'h20, 32'h0, 4'hF, 2'b01, 1);
    chk("a_be_data", {32'h0, rd_a}, {32'h0, 32'h11BB33DD});
    drop_all();
    chk("a_hold", {32'h0, rd_a}, {32'h0, 32'h11BB33DD});

    // Three wait states, back-to-back reads give 1,1,1,0,1,1,1,0
    access("b_wr0", 1, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 2'b01, 3);
    access("b_wr1", 1, 1'b1, 32'h104, 32'h01234567, 4'hF, 2'b01, 3);
    drop_all();
    access("b_rd0", 1, 1'b0, 32'h100, 32'h0, 4'h0, 2'b01, 3);
    chk("b_rd0_data", {32'h0, rd_b}, {32'h0, 32'hCAFEF00D});
    access("b_rd1", 1, 1'b0, 32'h104, 32'h0, 4'h0, 2'b01, 3);
    chk("b_rd1_data", {32'h0, rd_b}, {32'h0, 32'h01234567});
    drop_all();

    // Zero wait states: one access per cycle
    for (int i = 0; i < 4; i++)
      access("c_wr", 2, 1'b1, 32'(4 * i), 32'hA5000000 + 32'(i * 17), 4'hF, 2'b01, 0);
    for (int i = 0; i < 4; i++) begin
      access("c_rd", 2, 1'b0, 32'(4 * i), 32'h0, 4'h0, 2'b01, 0);
      chk("c_rd_data", {32'h0, rd_c}, {32'h0, 32'hA5000000 + 32'(i * 17)});
    end
    drop_all();

    // Two banks, two wait states
    access("d_wr1", 3, 1'b1, 32'h40, 32'h0BADCAFE, 4'hF, 2'b10, 2);
    access("d_rd1", 3, 1'b0, 32'h40, 32'h0, 4'h0, 2'b10, 2);
    chk("d_rd1_data", rd_d, {32'h0BADCAFE, 32'h0});
    access("d_wr0", 3, 1'b1, 32'h40, 32'h12345678, 4'hF, 2'b01, 2);
    access("d_rd0", 3, 1'b0, 32'h40, 32'h0, 4'h0, 2'b01, 2);
    chk("d_rd0_data", rd_d, {32'h0BADCAFE, 32'h12345678});

    // Abort: sram_en dropped in the second wait cycle
    wen = 1'b1; addr = 32'h40; wdata = 32'h5A5A5A5A; byte_en = 4'hF; en_d = 2'b01;
    #1 chk("abort_w0", {63'h0, wt_d}, 64'h1);
    step();
    en_d = 2'b00;
    #1 chk("abort_w1", {63'h0, wt_d}, 64'h0);
    step();
    access("abort_rd", 3, 1'b0, 32'h40, 32'h0, 4'h0, 2'b01, 2);
    chk("abort_data", rd_d, {32'h0BADCAFE, 32'h12345678});
    drop_all();

    // Multi-hot select: normal timing, no write, no read update
    access("mh_wr", 3, 1'b1, 32'h40, 32'hDEAD0000, 4'hF, 2'b11, 2);
    access("mh_rd", 3, 1'b0, 32'h40, 32'h0, 4'h0, 2'b11, 2);
    chk("mh_rd_hold", rd_d, {32'h0BADCAFE, 32'h12345678});
    access("mh_chk", 3, 1'b0, 32'h40, 32'h0, 4'h0, 2'b01, 2);
    chk("mh_no_write", rd_d, {32'h0BADCAFE, 32'h12345678});
    drop_all();

    // Reset in the middle of a write
    wen = 1'b1; addr = 32'h40; wdata = 32'hFFFFFFFF; byte_en = 4'hF; en_d = 2'b01;
    step();
    RST = 1'b1;
    #1 chk("rst_busy_wait", {63'h0, wt_d}, 64'h0);
    step();
    RST = 1'b0; en_d = 2'b00; wen = 1'b0;
    chk("rst_busy_rd", rd_d, 64'h0);
    step();
    access("rst_rd0", 3, 1'b0, 32'h40, 32'h0, 4'h0, 2'b01, 2);
    chk("rst_keep0", rd_d, {32'h0, 32'h12345678});
    access("rst_rd1", 3, 1'b0, 32'h40, 32'h0, 4'h0, 2'b10, 2);
    chk("rst_keep1", rd_d, {32'h0BADCAFE, 32'h12345678});

    // Address aliasing and ignored byte offset
    access("alias_wr", 3, 1'b1, 32'h1000, 32'h600DDA7A, 4'hF, 2'b01, 2);
    access("alias_rd", 3, 1'b0, 32'h0000, 32'h0, 4'h0, 2'b01, 2);
    chk("alias_data", rd_d, {32'h0BADCAFE, 32'h600DDA7A});
    access("offs_rd", 3, 1'b0, 32'h43, 32'h0, 4'h0, 2'b01, 2);
    chk("offs_data", rd_d, {32'h0BADCAFE, 32'h12345678});
    drop_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
